// File: rtl/his_builder_param_if.sv
// Event stream carrying one binned hit (pixel index + bin index) per transfer.
// An event transfers on a rising clk edge where data_valid && data_ready; pix/data are meaningful only while data_valid is high, and data_ready never depends on data_valid.
interface his_builder_param_if #(
  parameter int NB = 8,
  parameter int PW = 2
);
  logic          data_valid;
  logic [NB-1:0] data;
  logic [PW-1:0] pix;
  logic          data_ready;

  modport master (output data_valid, data, pix, input data_ready);
  modport slave  (input data_valid, data, pix, output data_ready);
endinterface

// File: rtl/his_builder_param.sv
// Histogram builder: clears a shared {pix,bin} count RAM, accumulates events with a
// read-modify-write pipeline, then scans every pixel and reports its peak bin.
module his_builder_param #(
  parameter int NB = 8,
  parameter int CW = 8,
  parameter int PW = 2,
  localparam int RAM_ADDR = PW + NB
) (
  input  logic                clk,
  input  logic                res,
  input  logic                start,
  input  logic                acq_done,
  output logic                busy,
  his_builder_param_if.slave  ev,
  input  logic [CW-1:0]       counts,
  output logic [RAM_ADDR-1:0] raddr,
  output logic                rEnable,
  output logic                readFlag,
  output logic [RAM_ADDR-1:0] waddr,
  output logic                wEnable,
  output logic                writeFlag,
  output logic [CW-1:0]       newCounts,
  output logic                peak_valid,
  output logic [PW-1:0]       peak_pix,
  output logic [NB-1:0]       peak_bin,
  output logic [CW-1:0]       peak_count,
  output logic                hisBuildDone,
  output logic [2:0]          o_dbg_state
);
  localparam logic [RAM_ADDR-1:0] LAST_ADDR = '1;
  localparam logic [CW-1:0]       CNT_MAX   = '1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACC, S_DRAIN, S_SCAN, S_DONE} state_t;

  state_t              r_state;
  logic [RAM_ADDR-1:0] r_addr;
  logic                r_clr_wen;
  logic                r_scan_ren;
  logic                r_ready;
  logic                r_s1_v;
  logic [RAM_ADDR-1:0] r_s1_addr;
  logic                r_fw_v;
  logic [RAM_ADDR-1:0] r_fw_addr;
  logic [CW-1:0]       r_fw_data;
  logic                r_rv;
  logic [RAM_ADDR-1:0] r_ra;
  logic [CW-1:0]       r_max;
  logic [NB-1:0]       r_max_bin;
  logic                r_pv;
  logic [PW-1:0]       r_ppix;
  logic [NB-1:0]       r_pbin;
  logic [CW-1:0]       r_pcnt;
  logic                r_done;

  logic                w_fire;
  logic [CW-1:0]       w_base;
  logic [CW-1:0]       w_inc;
  logic [NB-1:0]       w_bin;
  logic [PW-1:0]       w_pix;
  logic                w_take;
  logic [CW-1:0]       w_max_n;
  logic [NB-1:0]       w_bin_n;

  assign w_fire  = ev.data_valid & r_ready;
  // The RAM returns pre-write data for a read issued alongside the previous write, so forward it.
  assign w_base  = (r_fw_v && (r_fw_addr == r_s1_addr)) ? r_fw_data : counts;
  assign w_inc   = (w_base == CNT_MAX) ? CNT_MAX : w_base + 1'b1;

  assign w_bin   = r_ra[NB-1:0];
  assign w_pix   = r_ra[RAM_ADDR-1:NB];
  // Bin 0 always loads; later bins need a strictly larger count, so ties keep the lowest bin.
  assign w_take  = (w_bin == '0) || (counts > r_max);
  assign w_max_n = w_take ? counts : r_max;
  assign w_bin_n = w_take ? w_bin : r_max_bin;

  assign ev.data_ready = r_ready;
  assign busy          = (r_state != S_IDLE);
  assign rEnable       = w_fire | r_scan_ren;
  assign readFlag      = rEnable;
  assign raddr         = w_fire ? {ev.pix, ev.data} : r_addr;
  assign wEnable       = r_clr_wen | r_s1_v;
  assign writeFlag     = wEnable;
  assign waddr         = r_s1_v ? r_s1_addr : r_addr;
  assign newCounts     = r_s1_v ? w_inc : '0;
  assign peak_valid    = r_pv;
  assign peak_pix      = r_ppix;
  assign peak_bin      = r_pbin;
  assign peak_count    = r_pcnt;
  assign hisBuildDone  = r_done;
  assign o_dbg_state   = 3'(r_state);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_clr_wen  <= 1'b0;
      r_scan_ren <= 1'b0;
      r_ready    <= 1'b0;
      r_s1_v     <= 1'b0;
      r_s1_addr  <= '0;
      r_fw_v     <= 1'b0;
      r_fw_addr  <= '0;
      r_fw_data  <= '0;
      r_rv       <= 1'b0;
      r_ra       <= '0;
      r_max      <= '0;
      r_max_bin  <= '0;
      r_pv       <= 1'b0;
      r_ppix     <= '0;
      r_pbin     <= '0;
      r_pcnt     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_pv      <= 1'b0;
      r_done    <= 1'b0;
      r_s1_v    <= w_fire;
      r_s1_addr <= {ev.pix, ev.data};
      r_fw_v    <= r_s1_v;
      r_fw_addr <= r_s1_addr;
      r_fw_data <= w_inc;
      r_rv      <= r_scan_ren;
      r_ra      <= r_addr;

      if (r_rv) begin
        r_max     <= w_max_n;
        r_max_bin <= w_bin_n;
        if (w_bin == '1) begin
          r_pv   <= 1'b1;
          r_ppix <= w_pix;
          r_pbin <= w_bin_n;
          r_pcnt <= w_max_n;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_CLEAR;
            r_clr_wen <= 1'b1;
            r_addr    <= '0;
          end
        end
        S_CLEAR: begin
          if (r_addr == LAST_ADDR) begin
            r_clr_wen <= 1'b0;
            r_addr    <= '0;
            r_ready   <= 1'b1;
            r_state   <= S_ACC;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        S_ACC: begin
          if (acq_done) begin
            r_ready <= 1'b0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_scan_ren <= 1'b1;
          r_addr     <= '0;
          r_state    <= S_SCAN;
        end
        S_SCAN: begin
          if (r_scan_ren) begin
            if (r_addr == LAST_ADDR) r_scan_ren <= 1'b0;
            else                     r_addr     <= r_addr + 1'b1;
          end
          if (r_pv && (r_ppix == '1)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_his_builder_param.sv
// Bench for his_builder_param: behavioural RAM, histogram/argmax reference model,
// directed and randomized acquisitions including saturation and mid-scan reset.
module tb_his_builder_param;
  localparam int NB    = 4;
  localparam int CW    = 4;
  localparam int PW    = 1;
  localparam int RA    = PW + NB;
  localparam int NPIX  = 1 << PW;
  localparam int NBINS = 1 << NB;
  localparam int NADDR = NPIX * NBINS;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int W     = PW + NB + CW;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          start = 1'b0;
  logic          acq_done = 1'b0;
  logic          busy;
  logic [CW-1:0] counts;
  logic [RA-1:0] raddr;
  logic          rEnable, readFlag;
  logic [RA-1:0] waddr;
  logic          wEnable, writeFlag;
  logic [CW-1:0] newCounts;
  logic          peak_valid;
  logic [PW-1:0] peak_pix;
  logic [NB-1:0] peak_bin;
  logic [CW-1:0] peak_count;
  logic          hisBuildDone;
  logic [2:0]    dbg_state;

  his_builder_param_if #(.NB(NB), .PW(PW)) ev_if ();

  his_builder_param #(.NB(NB), .CW(CW), .PW(PW)) dut (
    .clk(clk), .res(res), .start(start), .acq_done(acq_done), .busy(busy),
    .ev(ev_if), .counts(counts), .raddr(raddr), .rEnable(rEnable), .readFlag(readFlag),
    .waddr(waddr), .wEnable(wEnable), .writeFlag(writeFlag), .newCounts(newCounts),
    .peak_valid(peak_valid), .peak_pix(peak_pix), .peak_bin(peak_bin),
    .peak_count(peak_count), .hisBuildDone(hisBuildDone), .o_dbg_state(dbg_state)
  );

  // clock / reset / environment
  always #5 clk = ~clk;

  logic [CW-1:0] mem [NADDR];
  always @(posedge clk) begin
    if (rEnable) counts <= mem[raddr];
    if (wEnable) mem[waddr] <= newCounts;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  int ref_hist [NPIX][NBINS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_peak(input int p);
    int best_b = 0;
    int best_c = ref_hist[p][0];
    logic [PW-1:0] pp;
    logic [NB-1:0] bb;
    logic [CW-1:0] cc;
    for (int b = 1; b < NBINS; b++)
      if (ref_hist[p][b] > best_c) begin
        best_c = ref_hist[p][b];
        best_b = b;
      end
    pp = p[PW-1:0];
    bb = best_b[NB-1:0];
    cc = best_c[CW-1:0];
    return {pp, bb, cc};
  endfunction

  always @(negedge clk) begin
    if (res && peak_valid) begin
      if (exp_q.size() == 0) check("peak_unexpected", 64'(peak_valid), 64'd0);
      else check("peak_value", 64'({peak_pix, peak_bin, peak_count}), 64'(exp_q.pop_front()));
    end
  end

  // driver tasks (all called at #1 after a rising edge)
  task automatic model_clear();
    for (int p = 0; p < NPIX; p++)
      for (int b = 0; b < NBINS; b++) ref_hist[p][b] = 0;
  endtask

  task automatic start_run(input string tag);
    model_clear();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < NADDR; i++) begin
      check({tag, "_clr_wen"}, 64'(wEnable), 64'd1);
      check({tag, "_clr_wflag"}, 64'(writeFlag), 64'd1);
      check({tag, "_clr_waddr"}, 64'(waddr), 64'(i));
      check({tag, "_clr_data"}, 64'(newCounts), 64'd0);
      check({tag, "_clr_notready"}, 64'(ev_if.data_ready), 64'd0);
      @(posedge clk); #1;
    end
    check({tag, "_acc_ready"}, 64'(ev_if.data_ready), 64'd1);
    check({tag, "_acc_nowrite"}, 64'(wEnable), 64'd0);
  endtask

  task automatic send_ev(input int p, input int b, input bit last);
    ev_if.data_valid = 1'b1;
    ev_if.pix  = p[PW-1:0];
    ev_if.data = b[NB-1:0];
    acq_done   = last;
    if (ref_hist[p][b] < CMAX) ref_hist[p][b]++;
    @(posedge clk); #1;
    ev_if.data_valid = 1'b0;
    acq_done = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic acq_only();
    acq_done = 1'b1;
    @(posedge clk); #1;
    acq_done = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int idx = 0;
    int npk = 0;
    bit got = 0;
    for (int p = 0; p < NPIX; p++) exp_q.push_back(ref_peak(p));
    @(posedge clk); #1;
    while (idx < 200 && !got) begin
      check({tag, "_scan_ren"}, 64'(rEnable), 64'(idx < NADDR));
      check({tag, "_scan_rflag"}, 64'(readFlag), 64'(idx < NADDR));
      if (idx < NADDR) check({tag, "_scan_raddr"}, 64'(raddr), 64'(idx));
      check({tag, "_scan_nowrite"}, 64'(wEnable), 64'd0);
      check({tag, "_scan_busy"}, 64'(busy), 64'd1);
      if (peak_valid) begin
        check({tag, "_peak_time"}, 64'(idx), 64'(NBINS * (npk + 1) + 1));
        npk++;
      end else if (npk > 0) begin
        check({tag, "_peak_hold"}, 64'({peak_pix, peak_bin, peak_count}), 64'(ref_peak(npk - 1)));
      end
      if (hisBuildDone) begin
        got = 1;
        check({tag, "_done_time"}, 64'(idx), 64'(NADDR + 2));
        check({tag, "_done_npeaks"}, 64'(npk), 64'(NPIX));
        check({tag, "_done_qempty"}, 64'(exp_q.size()), 64'd0);
      end else begin
        idx++;
        @(posedge clk); #1;
      end
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    @(posedge clk); #1;
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_done"}, 64'(hisBuildDone), 64'd0);
    check({tag, "_idle_nowrite"}, 64'(wEnable), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_ram(input string tag);
    for (int a = 0; a < NADDR; a++)
      check({tag, "_ram"}, 64'(mem[a]), 64'(ref_hist[a / NBINS][a % NBINS]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ready"}, 64'(ev_if.data_ready), 64'd0);
    check({tag, "_ren"}, 64'(rEnable), 64'd0);
    check({tag, "_rflag"}, 64'(readFlag), 64'd0);
    check({tag, "_raddr"}, 64'(raddr), 64'd0);
    check({tag, "_wen"}, 64'(wEnable), 64'd0);
    check({tag, "_wflag"}, 64'(writeFlag), 64'd0);
    check({tag, "_waddr"}, 64'(waddr), 64'd0);
    check({tag, "_newc"}, 64'(newCounts), 64'd0);
    check({tag, "_pvalid"}, 64'(peak_valid), 64'd0);
    check({tag, "_ppix"}, 64'(peak_pix), 64'd0);
    check({tag, "_pbin"}, 64'(peak_bin), 64'd0);
    check({tag, "_pcount"}, 64'(peak_count), 64'd0);
    check({tag, "_hdone"}, 64'(hisBuildDone), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // directed + random sequence
  initial begin
    int n, p, b;
    ev_if.data_valid = 1'b0;
    ev_if.pix  = '0;
    ev_if.data = '0;
    for (int a = 0; a < NADDR; a++) mem[a] = 4'hA;
    model_clear();

    #12;
    check_all_zero("rst");
    @(negedge clk) res = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_ready", 64'(ev_if.data_ready), 64'd0);

    // T1: clear sweep, then five back-to-back hits to pixel 1 bin 7
    start_run("t1");
    for (int i = 0; i < 5; i++) send_ev(1, 7, 1'b0);
    acq_only();
    wait_done("t1");
    check("t1_ram23", 64'(mem[23]), 64'd5);
    check_ram("t1");

    // T2: start ignored in ACC; tie between bins 3 and 9; empty pixel 1
    start_run("t2");
    start = 1'b1;
    idle_cycle();
    start = 1'b0;
    check("t2_start_ign_wen", 64'(wEnable), 64'd0);
    check("t2_start_ign_ready", 64'(ev_if.data_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      send_ev(0, 3, 1'b0);
      send_ev(0, 9, 1'b0);
    end
    acq_only();
    wait_done("t2");
    check("t2_ram3", 64'(mem[3]), 64'd4);
    check_ram("t2");

    // T3: saturation plus an event coincident with acq_done to a fresh bin
    start_run("t3");
    for (int i = 0; i < 20; i++) send_ev(0, 5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      p = $urandom_range(0, NPIX - 1);
      b = $urandom_range(0, NBINS - 1);
      if (p == 1 && b == 14) b = 13;
      send_ev(p, b, 1'b0);
    end
    send_ev(1, 14, 1'b1);
    wait_done("t3");
    check("t3_sat", 64'(mem[5]), 64'd15);
    check("t3_last_ev", 64'(mem[NBINS + 14]), 64'd1);
    check_ram("t3");

    // T4/T5: randomized acquisitions with gaps and repeated bins
    for (int r = 0; r < 3; r++) begin
      start_run("trand");
      n = $urandom_range(20, 70);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle_cycle();
        p = $urandom_range(0, NPIX - 1);
        b = $urandom_range(0, 3) == 0 ? 2 : $urandom_range(0, NBINS - 1);
        send_ev(p, b, (i == n - 1) && (r == 1));
      end
      if (r != 1) acq_only();
      wait_done("trand");
      check_ram("trand");
    end

    // T6: asynchronous reset in the middle of SCAN, then a fresh full run
    start_run("t6");
    for (int i = 0; i < 12; i++) send_ev($urandom_range(0, NPIX - 1), $urandom_range(0, NBINS - 1), 1'b0);
    acq_only();
    repeat (10) @(posedge clk);
    #3 res = 1'b0;
    #1 check_all_zero("midscan_rst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) res = 1'b1;
    @(posedge clk); #1;
    check("t6_idle_busy", 64'(busy), 64'd0);
    start_run("t6b");
    for (int i = 0; i < 15; i++) send_ev($urandom_range(0, NPIX - 1), $urandom_range(0, NBINS - 1), 1'b0);
    acq_only();
    wait_done("t6b");
    check_ram("t6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
